// File: rtl/vga_timing_detector.sv
// Measures incoming VGA sync/DE timing, locks after two identical frames and
// emits active-area coordinates aligned with the one-cycle-delayed DE.
module vga_timing_detector #(
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  output logic        o_de,
  output logic [15:0] o_sx,
  output logic [15:0] o_sy,
  output logic        o_frame,
  output logic        o_locked,
  output logic        o_h_pol,
  output logic        o_v_pol,
  output logic [15:0] o_h_res,
  output logic [15:0] o_v_res,
  output logic [15:0] o_h_total,
  output logic [15:0] o_v_total
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic        hs_r, vs_r, de_r, hs_p, vs_p, de_p;
  logic        pol_valid;
  logic [15:0] sx, sy;
  logic [15:0] h_cnt, h_total_m, de_run, h_res_m, v_cnt, v_line;
  logic [15:0] c_h_res, c_v_res, c_h_total, c_v_total;
  logic [15:0] f_h_res, f_v_res, f_h_total, f_v_total;
  logic [31:0] to_cnt;
  logic        hs_edge, vs_edge, de_fall, pol_change, timeout_hit, match;
  logic        load_cand, load_out;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Active edge = inactive-to-active transition under the learned polarity.
  assign hs_edge     = pol_valid && (hs_r == o_h_pol) && (hs_p != o_h_pol);
  assign vs_edge     = pol_valid && (vs_r == o_v_pol) && (vs_p != o_v_pol);
  assign de_fall     = de_p && !de_r;
  assign pol_change  = pol_valid && de_r && ((hs_r == o_h_pol) || (vs_r == o_v_pol));
  assign timeout_hit = !vs_edge && (to_cnt >= TO_LAST);

  assign o_de     = de_r;
  assign o_sx     = sx;
  assign o_sy     = sy;
  assign o_locked = (state == LOCKED);
  assign o_frame  = o_locked && de_r && (sx == 16'd0) && (sy == 16'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      de_r      <= 1'b0;
      hs_p      <= 1'b0;
      vs_p      <= 1'b0;
      de_p      <= 1'b0;
      pol_valid <= 1'b0;
      o_h_pol   <= 1'b0;
      o_v_pol   <= 1'b0;
    end else begin
      hs_r <= i_hs;
      vs_r <= i_vs;
      de_r <= i_de;
      hs_p <= hs_r;
      vs_p <= vs_r;
      de_p <= de_r;
      if (de_r) begin
        o_h_pol   <= ~hs_r;
        o_v_pol   <= ~vs_r;
        pol_valid <= 1'b1;
      end
    end
  end

  // sx advances in step with de_r so it lines up with o_de.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sx <= 16'd0;
      sy <= 16'd0;
    end else begin
      if (i_de && !de_r)
        sx <= 16'd0;
      else if (i_de)
        sx <= sat_inc(sx);
      if (vs_edge)
        sy <= 16'd0;
      else if (de_fall)
        sy <= sat_inc(sy);
    end
  end

  // A coincident hsync edge still belongs to the frame that is ending.
  assign f_h_total = hs_edge ? h_cnt : h_total_m;
  assign f_h_res   = de_fall ? de_run : h_res_m;
  assign f_v_total = hs_edge ? sat_inc(v_cnt) : v_cnt;
  assign f_v_res   = de_fall ? sat_inc(v_line) : v_line;
  assign match     = (f_h_res == c_h_res) && (f_v_res == c_v_res) &&
                     (f_h_total == c_h_total) && (f_v_total == c_v_total);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt     <= 16'd0;
      h_total_m <= 16'd0;
      de_run    <= 16'd0;
      h_res_m   <= 16'd0;
      v_cnt     <= 16'd0;
      v_line    <= 16'd0;
      to_cnt    <= 32'd0;
    end else begin
      if (hs_edge) begin
        h_cnt     <= 16'd1;
        h_total_m <= h_cnt;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
      if (de_r)
        de_run <= de_p ? sat_inc(de_run) : 16'd1;
      if (de_fall)
        h_res_m <= de_run;
      if (vs_edge) begin
        v_cnt  <= 16'd0;
        v_line <= 16'd0;
      end else begin
        if (hs_edge)
          v_cnt <= sat_inc(v_cnt);
        if (de_fall)
          v_line <= sat_inc(v_line);
      end
      if (vs_edge || timeout_hit)
        to_cnt <= 32'd0;
      else
        to_cnt <= to_cnt + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= SEARCH;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load_cand = 1'b0;
    load_out  = 1'b0;
    if (pol_change || timeout_hit) begin
      state_n = SEARCH;
    end else if (vs_edge) begin
      case (state)
        SEARCH:  state_n = MEASURE;
        MEASURE: begin
          state_n   = VERIFY;
          load_cand = 1'b1;
        end
        VERIFY: begin
          if (match) begin
            state_n  = LOCKED;
            load_out = 1'b1;
          end else begin
            load_cand = 1'b1;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_n   = VERIFY;
            load_cand = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  // Candidate is compared at each frame end; outputs move only on lock entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c_h_res   <= 16'd0;
      c_v_res   <= 16'd0;
      c_h_total <= 16'd0;
      c_v_total <= 16'd0;
      o_h_res   <= 16'd0;
      o_v_res   <= 16'd0;
      o_h_total <= 16'd0;
      o_v_total <= 16'd0;
    end else begin
      if (load_cand) begin
        c_h_res   <= f_h_res;
        c_v_res   <= f_v_res;
        c_h_total <= f_h_total;
        c_v_total <= f_v_total;
      end
      if (load_out) begin
        o_h_res   <= f_h_res;
        o_v_res   <= f_v_res;
        o_h_total <= f_h_total;
        o_v_total <= f_v_total;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector using two small video modes so that
// lock, mode change, timeout and reset all fit in a short run.
module tb_vga_timing_detector;

  logic        i_clk, i_rst, i_hs, i_vs, i_de;
  logic        o_de, o_frame, o_locked, o_h_pol, o_v_pol;
  logic [15:0] o_sx, o_sy, o_h_res, o_v_res, o_h_total, o_v_total;

  int total = 0;
  int bad   = 0;

  int h_tot, h_act, h_fp, h_sw, v_tot, v_act, v_fp, v_sw;
  bit pol_s;
  bit vs_en = 1'b1;

  vga_timing_detector #(.TIMEOUT_CYCLES(3000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .o_de(o_de), .o_sx(o_sx), .o_sy(o_sy), .o_frame(o_frame),
    .o_locked(o_locked), .o_h_pol(o_h_pol), .o_v_pol(o_v_pol),
    .o_h_res(o_h_res), .o_v_res(o_v_res), .o_h_total(o_h_total),
    .o_v_total(o_v_total)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Mode A: 32x20 active, 40x25 total. Mode B: 40x24 active, 52x30 total.
  task automatic set_mode(input bit mode_b, input bit pol);
    if (mode_b) begin
      h_tot = 52; h_act = 40; h_fp = 3; h_sw = 5;
      v_tot = 30; v_act = 24; v_fp = 2; v_sw = 3;
    end else begin
      h_tot = 40; h_act = 32; h_fp = 2; h_sw = 4;
      v_tot = 25; v_act = 20; v_fp = 2; v_sw = 2;
    end
    pol_s = pol;
  endtask

  task automatic drive_pixel(input int x, input int y);
    bit de, hs_a, vs_a;
    de   = (x < h_act) && (y < v_act);
    hs_a = (x >= h_act + h_fp) && (x < h_act + h_fp + h_sw);
    vs_a = vs_en && (y >= v_act + v_fp) && (y < v_act + v_fp + v_sw);
    i_de = de;
    i_hs = hs_a ? pol_s : ~pol_s;
    i_vs = vs_a ? pol_s : ~pol_s;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_frames(input int n, input bit chk, input bit exp_lock);
    int   pulses;
    logic exp_de, exp_frame;
    pulses = 0;
    for (int f = 0; f < n; f++)
      for (int y = 0; y < v_tot; y++)
        for (int x = 0; x < h_tot; x++) begin
          drive_pixel(x, y);
          if (chk) begin
            exp_de = (x < h_act) && (y < v_act);
            total++;
            if (o_de !== exp_de) begin
              bad++;
              $display("FAIL de at (%0d,%0d): got %b want %b", x, y, o_de, exp_de);
            end
            if (exp_de) begin
              total++;
              if (o_sx !== 16'(x)) begin
                bad++;
                $display("FAIL sx at (%0d,%0d): got %0d want %0d", x, y, o_sx, x);
              end
              total++;
              if (o_sy !== 16'(y)) begin
                bad++;
                $display("FAIL sy at (%0d,%0d): got %0d want %0d", x, y, o_sy, y);
              end
            end
            exp_frame = exp_lock && (x == 0) && (y == 0);
            total++;
            if (o_frame !== exp_frame) begin
              bad++;
              $display("FAIL frame at (%0d,%0d): got %b want %b", x, y, o_frame, exp_frame);
            end
            if (o_frame === 1'b1) pulses++;
          end
        end
    if (chk) begin
      total++;
      if (pulses != n) begin
        bad++;
        $display("FAIL frame_count: got %0d want %0d", pulses, n);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] got [11];
    i_rst = 1'b1; i_de = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    got = '{16'(o_de), o_sx, o_sy, 16'(o_frame), 16'(o_locked), 16'(o_h_pol),
            16'(o_v_pol), o_h_res, o_v_res, o_h_total, o_v_total};
    for (int i = 0; i < 11; i++) begin
      total++;
      if (got[i] !== 16'd0) begin
        bad++;
        $display("FAIL reset_out%0d: got %h want 0", i, got[i]);
      end
    end
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_locked: got %b want 0", o_locked);
    end
  endtask

  task automatic test_lock_negative();
    logic [15:0] got [6];
    int          exp [6];
    set_mode(1'b0, 1'b0);
    run_frames(2, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL neg_early_lock: got %b want 0", o_locked);
    end
    run_frames(1, 1'b0, 1'b0);
    got = '{16'(o_locked), 16'(o_h_pol), 16'(o_v_pol), o_h_res, o_v_res, o_h_total};
    exp = '{1, 0, 0, 32, 20, 40};
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== 16'(exp[i])) begin
        bad++;
        $display("FAIL neg_lock%0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
    total++;
    if (o_v_total !== 16'd25) begin
      bad++;
      $display("FAIL neg_v_total: got %0d want 25", o_v_total);
    end
  endtask

  task automatic test_locked_stream();
    run_frames(2, 1'b1, 1'b1);
    total++;
    if (o_locked !== 1'b1) begin
      bad++;
      $display("FAIL stream_locked: got %b want 1", o_locked);
    end
  endtask

  task automatic test_mode_change();
    logic [15:0] got [4];
    int          exp [4];
    set_mode(1'b1, 1'b0);
    run_frames(1, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL change_drop: got %b want 0", o_locked);
    end
    run_frames(1, 1'b0, 1'b0);
    got = '{o_h_res, o_v_res, o_h_total, o_v_total};
    exp = '{32, 20, 40, 25};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== 16'(exp[i])) begin
        bad++;
        $display("FAIL change_hold%0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL change_verify: got %b want 0", o_locked);
    end
    run_frames(1, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b1) begin
      bad++;
      $display("FAIL change_relock: got %b want 1", o_locked);
    end
    got = '{o_h_res, o_v_res, o_h_total, o_v_total};
    exp = '{40, 24, 52, 30};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== 16'(exp[i])) begin
        bad++;
        $display("FAIL change_meas%0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] got [4];
    int          exp [4];
    vs_en = 1'b0;
    run_frames(1, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got %b want 1", o_locked);
    end
    run_frames(1, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL timeout_drop: got %b want 0", o_locked);
    end
    got = '{o_h_res, o_v_res, o_h_total, o_v_total};
    exp = '{40, 24, 52, 30};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== 16'(exp[i])) begin
        bad++;
        $display("FAIL timeout_hold%0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
    vs_en = 1'b1;
  endtask

  task automatic test_reset_midline();
    logic [15:0] got [11];
    set_mode(1'b0, 1'b0);
    run_frames(3, 1'b0, 1'b0);
    got[0] = 16'(o_locked);
    got[1] = o_h_total;
    total++;
    if (got[0] !== 16'd1 || got[1] !== 16'd40) begin
      bad++;
      $display("FAIL midline_prelock: got locked=%0d h_total=%0d want 1/40", got[0], got[1]);
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < h_tot; x++) drive_pixel(x, y);
    for (int x = 0; x <= 10; x++) drive_pixel(x, 3);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    got = '{16'(o_de), o_sx, o_sy, 16'(o_frame), 16'(o_locked), 16'(o_h_pol),
            16'(o_v_pol), o_h_res, o_v_res, o_h_total, o_v_total};
    for (int i = 0; i < 11; i++) begin
      total++;
      if (got[i] !== 16'd0) begin
        bad++;
        $display("FAIL midline_out%0d: got %h want 0", i, got[i]);
      end
    end
    i_rst = 1'b0;
    run_frames(2, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL midline_early_lock: got %b want 0", o_locked);
    end
    run_frames(1, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b1 || o_h_res !== 16'd32 || o_v_res !== 16'd20) begin
      bad++;
      $display("FAIL midline_relock: got locked=%b h_res=%0d v_res=%0d want 1/32/20",
               o_locked, o_h_res, o_v_res);
    end
  endtask

  task automatic test_lock_positive();
    logic [15:0] got [7];
    int          exp [7];
    set_mode(1'b0, 1'b1);
    i_rst = 1'b1; i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    run_frames(2, 1'b0, 1'b0);
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL pos_early_lock: got %b want 0", o_locked);
    end
    run_frames(1, 1'b0, 1'b0);
    got = '{16'(o_locked), 16'(o_h_pol), 16'(o_v_pol), o_h_res, o_v_res, o_h_total, o_v_total};
    exp = '{1, 1, 1, 32, 20, 40, 25};
    for (int i = 0; i < 7; i++) begin
      total++;
      if (got[i] !== 16'(exp[i])) begin
        bad++;
        $display("FAIL pos_lock%0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_negative();
    test_locked_stream();
    test_mode_change();
    test_timeout();
    test_reset_midline();
    test_lock_positive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_detector.md
VGA_TIMING_DETECTOR -- requirements
Module: vga_timing_detector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4194304; no active vsync edge within this many cycles drops lock.
REQ-002 SHALL have port i_clk  input  1  sole clock; all inputs are synchronous to it.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_hs, i_vs, i_de  input  1 each  incoming sync and display-enable, any sync polarity.
REQ-005 SHALL have port o_de  output  1  i_de delayed by exactly one cycle.
REQ-006 SHALL have ports o_sx, o_sy  output  16 each  unsigned active-area coordinates, aligned with o_de.
REQ-007 SHALL have port o_frame  output  1  one-cycle pulse on the first o_de cycle of each frame.
REQ-008 SHALL have port o_locked  output  1  high while the measured timing is stable.
REQ-009 SHALL have ports o_h_pol, o_v_pol  output  1 each  detected polarity (1: positive, 0: negative).
REQ-010 SHALL have ports o_h_res, o_v_res, o_h_total, o_v_total  output  16 each  measured active/total pixels per line and lines per frame.

Function
REQ-011 SHALL register i_hs, i_vs, i_de once; all detection SHALL use the registered copies (1-cycle latency).
REQ-012 SHALL set the polarity flags on every cycle where registered de=1: pol = NOT sampled sync level (sync is inactive during active video).
REQ-013 SHALL assert polarity-valid after the first de=1 cycle following reset; no edge detection SHALL occur before that.
REQ-014 SHALL define the active edge of a sync as its transition from inactive to active level under the current polarity.
REQ-015 SHALL reset o_sx to 0 on each de rising edge and increment it on each subsequent de=1 cycle; o_sx holds while de=0.
REQ-016 SHALL reset o_sy to 0 on the vsync active edge; o_sy increments on the de falling edge of each line; first active line SHALL therefore be o_sy=0.
REQ-017 SHALL saturate all 16-bit counters at 0xFFFF; no wrap-around.
REQ-018 SHALL measure per line: h_total = cycles between consecutive hsync active edges; h_res = de=1 cycles in the last line containing de.
REQ-019 SHALL measure per frame: v_total = hsync active edges between consecutive vsync active edges; v_res = lines containing at least one de=1 cycle.
REQ-020 SHALL implement states SEARCH, MEASURE, VERIFY, LOCKED.
REQ-021 SEARCH -> MEASURE on first vsync active edge with polarity valid.
REQ-022 MEASURE -> VERIFY on next vsync active edge; the four measurements are stored as candidate.
REQ-023 VERIFY -> LOCKED on next vsync edge if all four measurements equal the candidate; otherwise store new candidate and stay in VERIFY.
REQ-024 LOCKED -> VERIFY on any frame whose measurements differ from the candidate, storing the new values as candidate; o_locked drops in the same cycle.
REQ-025 Any state -> SEARCH when TIMEOUT_CYCLES elapse without a vsync active edge; a polarity change SHALL also force SEARCH.
REQ-026 o_locked SHALL be 1 only in LOCKED; o_h_res/o_v_res/o_h_total/o_v_total SHALL update only on entry to LOCKED and hold otherwise.
REQ-027 o_frame SHALL pulse only in LOCKED, on the cycle o_de=1 with o_sx=0 and o_sy=0.
REQ-028 Coincident vsync and hsync active edges SHALL count the hsync edge in the ending frame's v_total.

Reset
REQ-029 On i_rst: state SEARCH; o_de, o_frame, o_locked, o_sx, o_sy, all measurement outputs = 0; o_h_pol, o_v_pol = 0; polarity-valid cleared; timeout counter cleared.
REQ-030 Reset asserted mid-frame SHALL take effect on the next clock edge and discard all candidates.

Verification
REQ-031 640x480@60 timing, both polarities negative (800x525 total) -> o_locked=1 after third vsync edge; h_res=640, v_res=480, h_total=800, v_total=525, h_pol=0, v_pol=0.
REQ-032 Same timing, positive polarities -> h_pol=1, v_pol=1, identical measurements and lock.
REQ-033 Locked stream: o_sx runs 0..639, o_sy 0..479 with o_de; o_frame high exactly once per frame at (0,0).
REQ-034 Locked, then switch to 800x600 timing (1056x628 total) -> o_locked drops at first differing frame, re-locks two frames later with new values.
REQ-035 Locked, then hold i_vs inactive for TIMEOUT_CYCLES -> state SEARCH, o_locked=0, measurement outputs hold.
REQ-036 Assert i_rst mid-line while locked -> next cycle all outputs 0; re-lock requires three further vsync edges.
